siw_memory_bram_pipe: RTL
=========================

Name: siw_memory_bram_pipe

Overview:
Parametrised, single-clock, true-dual-port memory bank for the SIW datapath.
- Each port has a programmable write-retiming delay of 0..MAX_DLY cycles and a fixed 2-cycle registered read path.
- Adds a hardware clear sequencer, byte-lane write enables and same-address write-collision detection.
- Sits between the SIW address generators and the bank array, one instance per bank.

Parameters:
DATA_W, 32, data width in bits; multiple of 8
ADDR_W, 10, address width; depth = 2**ADDR_W words
MAX_DLY, 3, maximum write-retiming delay in cycles, 1..7
CONF_W, 2, width of the mem_conf fields; must hold MAX_DLY

Ports:
siw_memory_bram_pipe_clk  in  1  single clock, rising edge
siw_memory_bram_pipe_reset  in  1  asynchronous active-high reset
siw_memory_bram_pipe_init  in  1  sync pulse: flush delay lines and start clear
siw_memory_bram_pipe_mem_sel  in  1  port A write allowed without enable_a (bank select)
siw_memory_bram_pipe_enable_a / _enable_b  in  1  port access enable
siw_memory_bram_pipe_write_en_a / _write_en_b  in  1  write request
siw_memory_bram_pipe_byte_en_a / _byte_en_b  in  DATA_W/8  byte-lane write mask
siw_memory_bram_pipe_address_a / _address_b  in  ADDR_W  word address
siw_memory_bram_pipe_input_data_a / _input_data_b  in  DATA_W  write data
siw_memory_bram_pipe_mem_conf_a / _mem_conf_b  in  CONF_W  write delay select, 0..MAX_DLY
siw_memory_bram_pipe_output_data_a / _output_data_b  out  DATA_W  registered read data
siw_memory_bram_pipe_busy  out  1  clear sequencer active
siw_memory_bram_pipe_done  out  1  one-cycle pulse when clear completes
siw_memory_bram_pipe_collision  out  1  one-cycle pulse on a same-address dual write

Behaviour:
Reset and clock:
- One clock; reset is asynchronous and active-high.
- On reset: delay lines, outputs, busy, done, collision and the clear counter go to 0; FSM goes to IDLE. Array contents are not reset.

Write delay line (per port):
- Stage 0 is the raw {write_en, byte_en, address, input_data}; stages 1..MAX_DLY are registered copies.
- mem_conf selects the stage applied to the array. mem_conf > MAX_DLY selects stage MAX_DLY.
- The whole tuple is delayed together, not only the strobe.

Write gating:
- Port A effective write = selected write_en & (enable_a | mem_sel) & !busy.
- Port B effective write = selected write_en & enable_b & !busy.
- enable and mem_sel are sampled undelayed, in the apply cycle.
- Only lanes with byte_en=1 are updated; all other lanes keep their old value.

Read path (per port):
- A read occurs when enable & !write_en (undelayed).
- Array read is registered, then passes through an output register: latency 2.
- output_data holds its value when no read occurs.
- Read-during-write on the same port and address returns the old data.

Collision:
- Both ports' effective writes hit the same address in the same cycle: port A lanes win on every lane that A enables; B writes only its lanes that A does not enable.
- collision is asserted for exactly one cycle, on the cycle after the conflicting writes.
- Port A read with port B write to the same address, or vice versa, returns the old data.

Clear FSM:
- States IDLE, CLEAR, DONE.
- IDLE -> CLEAR on init=1: counter := 0, busy := 1, all delay-line stages flushed to write_en=0.
- CLEAR: write all-zero words, all lanes, to address=counter; counter increments once per cycle.
- CLEAR -> DONE after address 2**ADDR_W-1 is written, so busy is high for exactly 2**ADDR_W cycles.
- DONE: busy := 0, done=1 for one cycle, then IDLE.
- init during CLEAR restarts the counter at 0. init during DONE re-enters CLEAR.
- While busy: user writes are dropped, not queued; reads still complete, and output_data is forced to 0.
- init also flushes the delay lines when the FSM is in IDLE.

Test Plan:
- Reset, then port A write 0xDEADBEEF to addr 5 with conf_a=0; read addr 5 two cycles later -> output_data_a=0xDEADBEEF, valid exactly 2 cycles after the read enable.
- conf_b=3: write 0x12345678 to addr 9 at cycle t, with enable_b held high through t+3 -> array updated at t+3; a read of addr 9 issued at t+2 returns the old value; a read issued at t+4 returns 0x12345678.
- Write addr 7 = 0xFFFFFFFF, then byte_en_a=4'b0101 with data 0 -> read 0xFF00FF00.
- Same-cycle writes to addr 3: A=0xAAAA_AAAA with byte_en 4'b0011, B=0xBBBB_BBBB with 4'b1111 -> addr 3 = 0xBBBBAAAA; collision=1 for one cycle.
- Pulse init with ADDR_W=4 -> busy high for 16 cycles, done pulses once, every address reads 0; a write attempted mid-clear is lost.
- Assert reset mid-CLEAR at counter=6 -> busy=0 and FSM in IDLE immediately; a second init completes a full 16-cycle clear.

Source files
------------

// File: rtl/siw_memory_bram_pipe_if.sv
// Port bundle for one SIW memory bank: write/read requests for ports A and B, clear control, status.
// The master side drives the requests; the slave side returns the read data and the clear/collision status.
interface siw_memory_bram_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CONF_W = 2
);
  localparam int BE_W = DATA_W / 8;

  logic              init;
  logic              mem_sel;
  logic              enable_a;
  logic              enable_b;
  logic              write_en_a;
  logic              write_en_b;
  logic [BE_W-1:0]   byte_en_a;
  logic [BE_W-1:0]   byte_en_b;
  logic [ADDR_W-1:0] address_a;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] input_data_a;
  logic [DATA_W-1:0] input_data_b;
  logic [CONF_W-1:0] mem_conf_a;
  logic [CONF_W-1:0] mem_conf_b;
  logic [DATA_W-1:0] output_data_a;
  logic [DATA_W-1:0] output_data_b;
  logic              busy;
  logic              done;
  logic              collision;

  modport master (
    output init, mem_sel, enable_a, enable_b, write_en_a, write_en_b,
    output byte_en_a, byte_en_b, address_a, address_b,
    output input_data_a, input_data_b, mem_conf_a, mem_conf_b,
    input  output_data_a, output_data_b, busy, done, collision
  );

  modport slave (
    input  init, mem_sel, enable_a, enable_b, write_en_a, write_en_b,
    input  byte_en_a, byte_en_b, address_a, address_b,
    input  input_data_a, input_data_b, mem_conf_a, mem_conf_b,
    output output_data_a, output_data_b, busy, done, collision
  );
endinterface

// File: rtl/siw_memory_bram_pipe.sv
// True-dual-port bank with per-port write retiming (0..MAX_DLY), hardware clear and collision flag.
// Read latency 2 cycles; no backpressure: writes arriving while the clear sequencer runs are dropped.
module siw_memory_bram_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int MAX_DLY = 3,
  parameter int CONF_W  = 2
) (
  input  logic                 siw_memory_bram_pipe_clk,
  input  logic                 siw_memory_bram_pipe_reset,
  siw_memory_bram_pipe_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } wr_t;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  logic clk;
  logic rst;
  assign clk = siw_memory_bram_pipe_clk;
  assign rst = siw_memory_bram_pipe_reset;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic              busy;
  logic              done;
  logic              collision;
  logic [ADDR_W-1:0] clr_cnt;

  wr_t               raw_a, raw_b, sel_a, sel_b;
  wr_t               dly_a [1:MAX_DLY];
  wr_t               dly_b [1:MAX_DLY];
  logic [CONF_W-1:0] idx_a, idx_b;
  logic              wr_a, wr_b, same_addr, rd_a, rd_b;
  logic              rd_a_q, rd_b_q;
  logic [DATA_W-1:0] rdata_a, rdata_b, out_a, out_b;

  assign raw_a = '{we: bus.write_en_a, be: bus.byte_en_a, addr: bus.address_a, dat: bus.input_data_a};
  assign raw_b = '{we: bus.write_en_b, be: bus.byte_en_b, addr: bus.address_b, dat: bus.input_data_b};

  assign idx_a = (bus.mem_conf_a > CONF_W'(MAX_DLY)) ? CONF_W'(MAX_DLY) : bus.mem_conf_a;
  assign idx_b = (bus.mem_conf_b > CONF_W'(MAX_DLY)) ? CONF_W'(MAX_DLY) : bus.mem_conf_b;

  always_comb begin
    sel_a = raw_a;
    sel_b = raw_b;
    for (int i = 1; i <= MAX_DLY; i++) begin
      if (int'(idx_a) == i) sel_a = dly_a[i];
      if (int'(idx_b) == i) sel_b = dly_b[i];
    end
  end

  // Bank select and enables gate in the apply cycle, not when the write was issued.
  assign wr_a      = sel_a.we & (bus.enable_a | bus.mem_sel) & ~busy;
  assign wr_b      = sel_b.we & bus.enable_b & ~busy;
  assign same_addr = wr_a & wr_b & (sel_a.addr == sel_b.addr);
  assign rd_a      = bus.enable_a & ~bus.write_en_a;
  assign rd_b      = bus.enable_b & ~bus.write_en_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= MAX_DLY; i++) begin
        dly_a[i] <= '0;
        dly_b[i] <= '0;
      end
    end else if (bus.init) begin
      for (int i = 1; i <= MAX_DLY; i++) begin
        dly_a[i] <= '0;
        dly_b[i] <= '0;
      end
    end else begin
      dly_a[1] <= raw_a;
      dly_b[1] <= raw_b;
      for (int i = 2; i <= MAX_DLY; i++) begin
        dly_a[i] <= dly_a[i-1];
        dly_b[i] <= dly_b[i-1];
      end
    end
  end

  // Port A lanes are written after port B so A wins any lane both ports enable.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (wr_b) begin
        for (int l = 0; l < BE_W; l++)
          if (sel_b.be[l] && !(same_addr && sel_a.be[l]))
            mem[sel_b.addr][l*8 +: 8] <= sel_b.dat[l*8 +: 8];
      end
      if (wr_a) begin
        for (int l = 0; l < BE_W; l++)
          if (sel_a.be[l])
            mem[sel_a.addr][l*8 +: 8] <= sel_a.dat[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_q    <= 1'b0;
      rd_b_q    <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
      out_a     <= '0;
      out_b     <= '0;
      collision <= 1'b0;
    end else begin
      rd_a_q    <= rd_a;
      rd_b_q    <= rd_b;
      collision <= same_addr;
      if (rd_a) rdata_a <= busy ? '0 : mem[bus.address_a];
      if (rd_b) rdata_b <= busy ? '0 : mem[bus.address_b];
      if (rd_a_q) out_a <= rdata_a;
      if (rd_b_q) out_b <= rdata_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      clr_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.init) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        CLEAR: begin
          if (bus.init) begin
            clr_cnt <= '0;
          end else if (clr_cnt == '1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.output_data_a = out_a;
  assign bus.output_data_b = out_b;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.collision     = collision;
endmodule
